axi4_lite_write_arbiter: RTL
============================

# axi4_lite_write_arbiter

Round-robin arbiter that shares one AXI4-Lite write master port between `NO_OF_REQUESTERS` local requesters. It sits between the requesters (sequences, register blocks, DMA stubs) and the AXI4-Lite write channels (AW, W, B). It serialises their write transfers: one outstanding transaction at a time. Addresses outside `[MIN_ADDRESS, MAX_ADDRESS]` are rejected locally with DECERR and never reach the bus.

## Interface
Parameters:
- `NO_OF_REQUESTERS`, 4: number of requesters, 2..8.
- `ADDRESS_WIDTH`, 32: AWADDR width.
- `DATA_WIDTH`, 32: WDATA width, multiple of 8; WSTRB width is `DATA_WIDTH/8`.
- `MIN_ADDRESS`, 32'h0000_0001: lowest legal address, inclusive.
- `MAX_ADDRESS`, 32'h0000_00FF: highest legal address, inclusive.

Ports (N = `NO_OF_REQUESTERS`, AW = `ADDRESS_WIDTH`, DW = `DATA_WIDTH`, SW = `DW/8`):
- `aclk` input 1: single clock; all logic is rising-edge.
- `aresetn` input 1: reset, asynchronous, active-low.
- `req_valid` input N: requester i has a write pending.
- `req_addr` input N*AW: requester i address in slice [i*AW +: AW].
- `req_prot` input N*3: requester i AWPROT.
- `req_data` input N*DW: requester i WDATA.
- `req_strb` input N*SW: requester i WSTRB.
- `req_ready` output N: one-hot acceptance strobe; payload is captured when `req_valid[i] & req_ready[i]`.
- `rsp_valid` output N: one-hot, one-cycle completion pulse.
- `rsp_bresp` output 2: response code, valid while `rsp_valid` is nonzero.
- `awvalid` output 1, `awready` input 1, `awaddr` output AW, `awprot` output 3: AXI4-Lite write address channel.
- `wvalid` output 1, `wready` input 1, `wdata` output DW, `wstrb` output SW: AXI4-Lite write data channel.
- `bvalid` input 1, `bready` output 1, `bresp` input 2: AXI4-Lite write response channel.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE
  - ADDR_DATA: AW and W are driven.
  - RESP: waiting for B.
  - DONE: completion pulse.
- IDLE, request arbitration:
  - Grant g is the first set bit of `req_valid`, searching circularly from `last_grant+1`.
  - `req_ready[g]` is combinationally high in the same cycle; all other `req_ready` bits are low.
  - At the clock edge, the payload of g is registered and g is stored in `cur`.
  - `last_grant` is updated to g; its reset value is N-1, so requester 0 wins first.
  - `req_ready` is always 0 outside IDLE.
- IDLE to ADDR_DATA when the captured address is in range.
- IDLE to DONE when the address is out of range, i.e. `addr < MIN_ADDRESS` or `addr > MAX_ADDRESS`, unsigned compare.
  - `rsp_bresp` is 2'b11 (DECERR).
  - No AXI channel activity.
- ADDR_DATA:
  - `awvalid` and `wvalid` both rise on entry.
  - Each is deasserted independently on the edge where it is sampled with its ready high.
  - `awaddr`, `awprot`, `wdata` and `wstrb` stay stable while their valid is high.
  - Valid never drops without its handshake.
  - Go to RESP on the edge where the last outstanding handshake completes.
  - AW and W completing in the same cycle is legal.
- RESP:
  - `bready` is high for the whole state.
  - On the edge where `bvalid & bready`, `bresp` is registered into `rsp_bresp`, `bready` goes low, and the FSM goes to DONE.
- DONE:
  - `rsp_valid[cur]` is high for exactly one cycle.
  - The FSM then returns to IDLE.
  - New grants are only evaluated in IDLE, so at least one IDLE cycle separates transactions.
- `busy` is 0 in IDLE and 1 in every other state.

## Timing
- Reset values: `awvalid`, `wvalid` and `bready` = 0; `awaddr`, `awprot`, `wdata` and `wstrb` = 0; `req_ready` and `rsp_valid` = 0; `rsp_bresp` = 2'b00; `busy` = 0.
- Reset internal state: FSM in IDLE; `last_grant` = N-1.
- Reset asserted mid-transaction:
  - All outputs return to their reset values immediately, which is asynchronous.
  - The in-flight request is dropped with no `rsp_valid` pulse.
  - Requesters re-issue.
- In-range latency, with accept at edge 0:
  - `awvalid`/`wvalid` are high in cycle 1.
  - With zero-wait `awready`/`wready`/`bvalid`: handshakes at edge 1, `bready` high in cycle 2, B handshake at edge 2, `rsp_valid` in cycle 3.
  - Minimum accept-to-response latency is 3 cycles; the next accept is possible in cycle 4.
- Out-of-range latency: `rsp_valid` in cycle 1 after accept; no AXI signal toggles.
- All AXI outputs are driven directly from flops.
- `req_ready` is the only combinational output; it depends on `req_valid`, state and `last_grant`.
- A `bvalid` arriving outside RESP is ignored, because `bready` is 0 there.
- A `req_valid` dropped before grant is legal and simply loses arbitration.

## Test plan
- Single request: requester 0 writes addr 8'h10, data 32'hDEAD_BEEF, strb 4'hF, with zero-wait slave -> AW/W in cycle 1, `rsp_valid` = 4'b0001 in cycle 3, `rsp_bresp` = 2'b00.
- Round-robin fairness: all 4 requesters hold `req_valid` continuously -> grant order 0,1,2,3,0,...; after requester 2 is served, a request from 1 and 3 selects 3.
- Independent handshakes: `awready` delayed 3 cycles, `wready` delayed 0, `bvalid` delayed 5 -> `wvalid` drops after 1 cycle, `awvalid` after 4; `bready` is held until `bvalid`; `rsp_bresp` = slave value, e.g. 2'b10 SLVERR.
- Range check: requester 1 writes addr 8'h00 and then addr 32'h100 -> no `awvalid`/`wvalid`; `rsp_valid` = 4'b0010 one cycle after accept, `rsp_bresp` = 2'b11; addr 8'hFF is accepted onto the bus.
- Stability: `awready`/`wready` held low 10 cycles while a different `req_valid` toggles -> `awaddr`/`wdata` unchanged and `req_ready` = 0.
- Reset mid-RESP: `aresetn` pulsed low while `bready` = 1 -> all outputs at reset values immediately, no `rsp_valid`; the next grant goes to requester 0.

Source files
------------

// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write master between local requesters.
// One transaction is in flight at a time; out-of-range addresses complete locally with DECERR.
module axi4_lite_write_arbiter #(
  parameter int unsigned NO_OF_REQUESTERS = 4,
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = ADDRESS_WIDTH'(32'h0000_0001),
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = ADDRESS_WIDTH'(32'h0000_00FF)
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [NO_OF_REQUESTERS-1:0]               req_valid,
  input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NO_OF_REQUESTERS*3-1:0]             req_prot,
  input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]    req_data,
  input  logic [NO_OF_REQUESTERS*DATA_WIDTH/8-1:0]  req_strb,
  output logic [NO_OF_REQUESTERS-1:0]               req_ready,
  output logic [NO_OF_REQUESTERS-1:0]               rsp_valid,
  output logic [1:0]                                rsp_bresp,
  output logic                                      awvalid,
  input  logic                                      awready,
  output logic [ADDRESS_WIDTH-1:0]                  awaddr,
  output logic [2:0]                                awprot,
  output logic                                      wvalid,
  input  logic                                      wready,
  output logic [DATA_WIDTH-1:0]                     wdata,
  output logic [DATA_WIDTH/8-1:0]                   wstrb,
  input  logic                                      bvalid,
  output logic                                      bready,
  input  logic [1:0]                                bresp,
  output logic                                      busy
);

  localparam int unsigned N  = NO_OF_REQUESTERS;
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, DONE} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic [GW-1:0]   cur, cur_d;
  logic            awvalid_d, wvalid_d, bready_d, busy_d;
  logic [AW-1:0]   awaddr_d;
  logic [2:0]      awprot_d;
  logic [DW-1:0]   wdata_d;
  logic [SW-1:0]   wstrb_d;
  logic [N-1:0]    rsp_valid_d;
  logic [1:0]      rsp_bresp_d;

  logic [GW-1:0]   grant, idx;
  logic            grant_found;
  logic [N-1:0]    grant_oh;
  logic [AW-1:0]   sel_addr;
  logic [2:0]      sel_prot;
  logic [DW-1:0]   sel_data;
  logic [SW-1:0]   sel_strb;
  logic            in_range;

  // Circular search for the first pending requester after the last winner
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = GW'((32'(last_grant) + 32'd1 + k) % N);
      if (!grant_found && req_valid[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  assign grant_oh  = grant_found ? (N'(1) << grant) : '0;
  assign req_ready = (state == IDLE) ? grant_oh : '0;

  assign sel_addr = req_addr[32'(grant)*AW +: AW];
  assign sel_prot = req_prot[32'(grant)*3 +: 3];
  assign sel_data = req_data[32'(grant)*DW +: DW];
  assign sel_strb = req_strb[32'(grant)*SW +: SW];
  assign in_range = !(sel_addr < MIN_ADDRESS) && !(sel_addr > MAX_ADDRESS);

  // Next-state and next-output logic; every output is taken from a flop
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cur_d        = cur;
    awvalid_d    = awvalid;
    wvalid_d     = wvalid;
    bready_d     = bready;
    awaddr_d     = awaddr;
    awprot_d     = awprot;
    wdata_d      = wdata;
    wstrb_d      = wstrb;
    rsp_bresp_d  = rsp_bresp;
    rsp_valid_d  = '0;
    busy_d       = 1'b0;

    case (state)
      IDLE: begin
        if (grant_found) begin
          last_grant_d = grant;
          cur_d        = grant;
          if (in_range) begin
            state_d   = ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = sel_addr;
            awprot_d  = sel_prot;
            wdata_d   = sel_data;
            wstrb_d   = sel_strb;
          end else begin
            state_d     = DONE;
            rsp_bresp_d = 2'b11;
          end
        end
      end
      ADDR_DATA: begin
        awvalid_d = awvalid & ~awready;
        wvalid_d  = wvalid & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (bvalid && bready) begin
          state_d     = DONE;
          bready_d    = 1'b0;
          rsp_bresp_d = bresp;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      rsp_valid_d = N'(1) << cur_d;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= GW'(N - 1);
      cur        <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      awaddr     <= '0;
      awprot     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      rsp_valid  <= '0;
      rsp_bresp  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      cur        <= cur_d;
      awvalid    <= awvalid_d;
      wvalid     <= wvalid_d;
      bready     <= bready_d;
      awaddr     <= awaddr_d;
      awprot     <= awprot_d;
      wdata      <= wdata_d;
      wstrb      <= wstrb_d;
      rsp_valid  <= rsp_valid_d;
      rsp_bresp  <= rsp_bresp_d;
      busy       <= busy_d;
    end
  end

endmodule
